// File: rtl/partial_sums_distributor_mf.sv
// partial_sums_distributor_mf
//   Multi-frame partial-sums distributor for a semi-parallel SC decoder.
//   Converts scheduler indices (bit/stage/exe) into a one-hot partial-sum
//   select vector, per-PE lane selects and a PSN update enable, through a
//   PIPE-deep valid pipeline. Also generates one PSN reset pulse per frame.
//
// Ports
//   clk, rst            clock (rising edge), async active-high reset
//   start, frame_id     new-frame request for frame_id (masked by decoder_busy)
//   decoder_busy        decoder mid-frame
//   in_valid            bit_index/stage_index/exe_index valid this cycle
//   psn_rst[FRAMES]     registered single-cycle per-frame PSN reset
//   psn_en              out_valid of a stage-0 sample
//   out_valid/out_frame sample valid / its frame
//   distribute_vector   one-hot select, 1 << ((bit - used) mod 2**N_LOG)
//   lane_sel            lane k at [k*N_LOG +: N_LOG] = used + k
//   err_underflow       bit_index < used for the current valid sample
module partial_sums_distributor_mf #(
  parameter int N_LOG  = 3,
  parameter int P_LOG  = 1,
  parameter int FRAMES = 1,
  parameter int PIPE   = 2,
  localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1,
  localparam int SW = (N_LOG > 1) ? $clog2(N_LOG) : 1,
  localparam int EW = N_LOG - P_LOG,
  localparam int NV = 1 << N_LOG,
  localparam int NL = 1 << P_LOG,
  localparam int LW = NL * N_LOG
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [FW-1:0] frame_id,
  input  logic          decoder_busy,
  input  logic          in_valid,
  input  logic [N_LOG-1:0] bit_index,
  input  logic [SW-1:0] stage_index,
  input  logic [EW-1:0] exe_index,
  output logic [FRAMES-1:0] psn_rst,
  output logic          psn_en,
  output logic          out_valid,
  output logic [FW-1:0] out_frame,
  output logic [NV-1:0] distribute_vector,
  output logic [LW-1:0] lane_sel,
  output logic          err_underflow
);

  // vld_pipe_q[1] is the index stage, vld_pipe_q[PIPE] drives out_valid
  logic [PIPE:1] vld_pipe_q, vld_pipe_d;

  // stage 1: registered indices
  logic [N_LOG-1:0] bit_q, bit_d;
  logic [SW-1:0]    st_q, st_d;
  logic [EW-1:0]    exe_q, exe_d;
  logic [FW-1:0]    frm1_q, frm1_d;

  // stages 2..PIPE: results; only loaded by a valid sample so bubbles hold
  logic [PIPE:2][NV-1:0] vec_q, vec_d;
  logic [PIPE:2][LW-1:0] lane_q, lane_d;
  logic [PIPE:2][FW-1:0] frm_q, frm_d;
  logic [PIPE:2]         err_q, err_d, s0_q, s0_d;

  logic [FRAMES-1:0] psn_rst_q, psn_rst_d;

  // result computation from stage 1
  logic [N_LOG-1:0] used_c, off_c;
  logic [NV-1:0]    vec_c;
  logic [LW-1:0]    lane_c;
  logic             err_c;

  always_comb begin
    if (32'(st_q) >= P_LOG) used_c = N_LOG'(exe_q) << P_LOG;
    else                    used_c = N_LOG'(1) << st_q;
    off_c = bit_q - used_c;      // wraps mod 2**N_LOG
    vec_c = NV'(1) << off_c;
    err_c = bit_q < used_c;
  end

  for (genvar k = 0; k < NL; k++) begin : g_lane
    assign lane_c[k*N_LOG +: N_LOG] = used_c + N_LOG'(k);
  end

  always_comb begin
    vld_pipe_d = {vld_pipe_q[PIPE-1:1], in_valid};

    bit_d  = bit_q;
    st_d   = st_q;
    exe_d  = exe_q;
    frm1_d = frm1_q;
    if (in_valid) begin
      bit_d  = bit_index;
      st_d   = stage_index;
      exe_d  = exe_index;
      frm1_d = frame_id;
    end

    vec_d  = vec_q;
    lane_d = lane_q;
    frm_d  = frm_q;
    err_d  = err_q;
    s0_d   = s0_q;
    if (vld_pipe_q[1]) begin
      vec_d[2]  = vec_c;
      lane_d[2] = lane_c;
      frm_d[2]  = frm1_q;
      err_d[2]  = err_c;
      s0_d[2]   = (st_q == '0);
    end
    for (int i = 3; i <= PIPE; i++) begin
      if (vld_pipe_q[i-1]) begin
        vec_d[i]  = vec_q[i-1];
        lane_d[i] = lane_q[i-1];
        frm_d[i]  = frm_q[i-1];
        err_d[i]  = err_q[i-1];
        s0_d[i]   = s0_q[i-1];
      end
    end

    for (int f = 0; f < FRAMES; f++)
      psn_rst_d[f] = start & ~decoder_busy & (frame_id == FW'(f));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      bit_q      <= '0;
      st_q       <= '0;
      exe_q      <= '0;
      frm1_q     <= '0;
      vec_q      <= '0;
      lane_q     <= '0;
      frm_q      <= '0;
      err_q      <= '0;
      s0_q       <= '0;
      psn_rst_q  <= '1;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      bit_q      <= bit_d;
      st_q       <= st_d;
      exe_q      <= exe_d;
      frm1_q     <= frm1_d;
      vec_q      <= vec_d;
      lane_q     <= lane_d;
      frm_q      <= frm_d;
      err_q      <= err_d;
      s0_q       <= s0_d;
      psn_rst_q  <= psn_rst_d;
    end
  end

  assign psn_rst           = psn_rst_q;
  assign out_valid         = vld_pipe_q[PIPE];
  assign psn_en            = vld_pipe_q[PIPE] & s0_q[PIPE];
  assign err_underflow     = vld_pipe_q[PIPE] & err_q[PIPE];
  assign out_frame         = frm_q[PIPE];
  assign distribute_vector = vec_q[PIPE];
  assign lane_sel          = lane_q[PIPE];

endmodule

// File: tb/tb_partial_sums_distributor_mf.sv
module tb_partial_sums_distributor_mf;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // instance A: N_LOG=3 P_LOG=1 FRAMES=1 PIPE=2
  logic a_rst, a_start, a_busy, a_iv;
  logic [0:0] a_fid, a_ofrm;
  logic [2:0] a_bit;
  logic [1:0] a_st, a_exe;
  logic [0:0] a_prst;
  logic a_en, a_ov, a_err;
  logic [7:0] a_vec;
  logic [5:0] a_lane;

  partial_sums_distributor_mf #(.N_LOG(3), .P_LOG(1), .FRAMES(1), .PIPE(2)) u_a (
    .clk(clk), .rst(a_rst), .start(a_start), .frame_id(a_fid), .decoder_busy(a_busy),
    .in_valid(a_iv), .bit_index(a_bit), .stage_index(a_st), .exe_index(a_exe),
    .psn_rst(a_prst), .psn_en(a_en), .out_valid(a_ov), .out_frame(a_ofrm),
    .distribute_vector(a_vec), .lane_sel(a_lane), .err_underflow(a_err));

  // instance B: FRAMES=2 PIPE=4
  logic b_rst, b_start, b_busy, b_iv;
  logic [0:0] b_fid, b_ofrm;
  logic [2:0] b_bit;
  logic [1:0] b_st, b_exe;
  logic [1:0] b_prst;
  logic b_en, b_ov, b_err;
  logic [7:0] b_vec;
  logic [5:0] b_lane;

  partial_sums_distributor_mf #(.N_LOG(3), .P_LOG(1), .FRAMES(2), .PIPE(4)) u_b (
    .clk(clk), .rst(b_rst), .start(b_start), .frame_id(b_fid), .decoder_busy(b_busy),
    .in_valid(b_iv), .bit_index(b_bit), .stage_index(b_st), .exe_index(b_exe),
    .psn_rst(b_prst), .psn_en(b_en), .out_valid(b_ov), .out_frame(b_ofrm),
    .distribute_vector(b_vec), .lane_sel(b_lane), .err_underflow(b_err));

  task automatic a_drive(input logic v, input logic [1:0] st, input logic [1:0] exe, input logic [2:0] b);
    a_iv = v; a_st = st; a_exe = exe; a_bit = b;
  endtask

  initial begin
    a_rst = 1'b1; a_start = 0; a_fid = 0; a_busy = 0; a_drive(0, 0, 0, 0);
    b_rst = 1'b1; b_start = 0; b_fid = 0; b_busy = 0; b_iv = 0; b_st = 0; b_exe = 0; b_bit = 0;
    #1;
    // reset state
    chk("rst_psn_rst", 64'(a_prst), 64'h1);
    chk("rst_psn_en",  64'(a_en),   64'h0);
    chk("rst_ov",      64'(a_ov),   64'h0);
    chk("rst_vec",     64'(a_vec),  64'h0);
    chk("rst_lane",    64'(a_lane), 64'h0);
    chk("rst_err",     64'(a_err),  64'h0);
    chk("rst_b_psn_rst", 64'(b_prst), 64'h3);
    tick(); tick();
    a_rst = 1'b0;
    b_rst = 1'b0;
    tick();
    chk("a_psn_rst_idle", 64'(a_prst), 64'h0);

    // stage=2 exe=1 bit=5 -> used 2, offset 3
    a_drive(1, 2, 1, 5); tick();
    // stage=0 bit=6 -> used 1, offset 5
    a_drive(1, 0, 0, 6); tick();
    chk("t2_ov",   64'(a_ov),   64'h1);
    chk("t2_vec",  64'(a_vec),  64'h08);
    chk("t2_lane", 64'(a_lane), 64'({3'd3, 3'd2}));
    chk("t2_en",   64'(a_en),   64'h0);
    chk("t2_err",  64'(a_err),  64'h0);
    // stage=2 exe=1 bit=1 -> underflow, offset 7
    a_drive(1, 2, 1, 1); tick();
    chk("t3_ov",   64'(a_ov),   64'h1);
    chk("t3_vec",  64'(a_vec),  64'h20);
    chk("t3_lane", 64'(a_lane), 64'({3'd2, 3'd1}));
    chk("t3_en",   64'(a_en),   64'h1);
    // stage=1 exe=3 bit=7 -> used 6, offset 1
    a_drive(1, 1, 3, 7); tick();
    chk("t4_vec",  64'(a_vec),  64'h80);
    chk("t4_err",  64'(a_err),  64'h1);
    chk("t4_lane", 64'(a_lane), 64'({3'd3, 3'd2}));
    chk("t4_en",   64'(a_en),   64'h0);
    a_drive(0, 0, 0, 0); tick();
    chk("t5_vec",  64'(a_vec),  64'h02);
    chk("t5_lane", 64'(a_lane), 64'({3'd7, 3'd6}));
    chk("t5_err",  64'(a_err),  64'h0);
    tick();
    // bubble: valid drops, data holds
    chk("bub_ov",   64'(a_ov),   64'h0);
    chk("bub_en",   64'(a_en),   64'h0);
    chk("bub_vec",  64'(a_vec),  64'h02);
    chk("bub_lane", 64'(a_lane), 64'({3'd7, 3'd6}));

    // per-frame psn_rst
    b_start = 1; b_fid = 1; b_busy = 0; tick();
    chk("t5_pulse", 64'(b_prst), 64'h2);
    b_start = 0; tick();
    chk("t5_single", 64'(b_prst), 64'h0);
    b_start = 1; b_fid = 1; b_busy = 1; tick();
    chk("t5_busy", 64'(b_prst), 64'h0);
    b_fid = 0; b_busy = 0; tick();
    chk("t5_f0", 64'(b_prst), 64'h1);
    b_start = 0; tick();

    // PIPE=4 stream, stage 0 -> used 1, offset bit-1
    for (int i = 0; i < 6; i++) begin
      b_iv = 1; b_st = 0; b_bit = 3'(i); tick();
      if (i < 3) chk($sformatf("s_ov_early%0d", i), 64'(b_ov), 64'h0);
      else begin
        chk($sformatf("s_ov%0d", i), 64'(b_ov), 64'h1);
        chk($sformatf("s_vec%0d", i), 64'(b_vec), 64'(8'(1) << 3'(i - 4)));
        chk($sformatf("s_frm%0d", i), 64'(b_ofrm), 64'h0);
      end
    end
    b_rst = 1'b1; #1;
    chk("mid_rst_ov",  64'(b_ov),   64'h0);
    chk("mid_rst_vec", 64'(b_vec),  64'h0);
    chk("mid_rst_prst", 64'(b_prst), 64'h3);
    tick(); tick();
    b_rst = 1'b0; b_bit = 3'd2;
    for (int i = 1; i <= 4; i++) begin
      tick();
      b_bit = 3'd5;
      if (i < 4) begin
        chk($sformatf("rs_ov%0d", i), 64'(b_ov), 64'h0);
        chk($sformatf("rs_vec%0d", i), 64'(b_vec), 64'h0);
      end else begin
        chk("rs_ov4",  64'(b_ov),  64'h1);
        chk("rs_vec4", 64'(b_vec), 64'h02);
        chk("rs_en4",  64'(b_en),  64'h1);
      end
    end
    b_iv = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
